// File: rtl/stack_ptr_ctrl_if.sv
// Operation handshake and stack-pointer status bundle between the control
// unit (master) and the stack-pointer controller (slave).
interface stack_ptr_ctrl_if #(
  parameter int WIDTH = 14
);
  logic             op_valid;
  logic             op_ready;
  logic [1:0]       op_code;
  logic [WIDTH-1:0] op_count;
  logic             err_clr;
  logic [WIDTH-1:0] sp;
  logic             empty;
  logic             full;
  logic             done;
  logic             err_ovf;
  logic             err_unf;

  modport master (
    output op_valid, op_code, op_count, err_clr,
    input  op_ready, sp, empty, full, done, err_ovf, err_unf
  );

  modport slave (
    input  op_valid, op_code, op_count, err_clr,
    output op_ready, sp, empty, full, done, err_ovf, err_unf
  );
endinterface

// File: rtl/stack_ptr_ctrl.sv
// Stack-pointer controller: owns the downward-growing stack pointer, sequences
// multi-word allocation through the shared decrementer, and reports sticky errors.

module subone14b #(
  parameter int WIDTH = 14
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  assign y = a - WIDTH'(1);
endmodule

module stack_ptr_ctrl #(
  parameter int               WIDTH    = 14,
  parameter logic [WIDTH-1:0] SP_TOP   = 14'h3FFF,
  parameter logic [WIDTH-1:0] SP_LIMIT = 14'h3C00
) (
  input  logic            clk,
  input  logic            rst_n,
  stack_ptr_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ALLOC = 1'b1
  } state_t;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_ALLOC = 2'b10;
  localparam logic [1:0] OP_FREE  = 2'b11;

  state_t           state_r, state_nx_s;
  logic [WIDTH-1:0] sp_r, sp_nx_s;
  logic [WIDTH-1:0] cnt_r, cnt_nx_s;
  logic             done_r, done_nx_s;
  logic             err_ovf_r, err_unf_r;
  logic             set_ovf_s, set_unf_s;
  logic [WIDTH-1:0] sp_dec_s, cnt_dec_s;
  logic             empty_s, full_s;
  logic [WIDTH:0]   room_s;
  logic             free_bad_s;

  subone14b #(.WIDTH(WIDTH)) u_sp_dec  (.a(sp_r),  .y(sp_dec_s));
  subone14b #(.WIDTH(WIDTH)) u_cnt_dec (.a(cnt_r), .y(cnt_dec_s));

  assign empty_s = (sp_r == SP_TOP);
  assign full_s  = (sp_r == SP_LIMIT);
  // Words that can still be freed; sp never exceeds SP_TOP so this never wraps.
  assign room_s     = {1'b0, SP_TOP} - {1'b0, sp_r};
  assign free_bad_s = ({1'b0, bus.op_count} > room_s);

  // Next-state, next-pointer and error-set decode.
  always_comb begin
    state_nx_s = state_r;
    sp_nx_s    = sp_r;
    cnt_nx_s   = cnt_r;
    done_nx_s  = 1'b0;
    set_ovf_s  = 1'b0;
    set_unf_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.op_valid) begin
          case (bus.op_code)
            OP_PUSH: begin
              done_nx_s = 1'b1;
              if (full_s) begin
                set_ovf_s = 1'b1;
              end else begin
                sp_nx_s = sp_dec_s;
              end
            end
            OP_POP: begin
              done_nx_s = 1'b1;
              if (empty_s) begin
                set_unf_s = 1'b1;
              end else begin
                sp_nx_s = sp_r + WIDTH'(1);
              end
            end
            OP_FREE: begin
              done_nx_s = 1'b1;
              if (free_bad_s) begin
                set_unf_s = 1'b1;
              end else begin
                sp_nx_s = sp_r + bus.op_count;
              end
            end
            OP_ALLOC: begin
              if (bus.op_count == {WIDTH{1'b0}}) begin
                done_nx_s = 1'b1;
              end else begin
                cnt_nx_s   = bus.op_count;
                state_nx_s = ST_ALLOC;
              end
            end
            default: begin
              done_nx_s = 1'b0;
            end
          endcase
        end else begin
          done_nx_s = 1'b0;
        end
      end
      ST_ALLOC: begin
        // Hitting the limit aborts; words already allocated are kept.
        if (full_s) begin
          set_ovf_s  = 1'b1;
          done_nx_s  = 1'b1;
          cnt_nx_s   = {WIDTH{1'b0}};
          state_nx_s = ST_IDLE;
        end else begin
          sp_nx_s  = sp_dec_s;
          cnt_nx_s = cnt_dec_s;
          if (cnt_r == WIDTH'(1)) begin
            done_nx_s  = 1'b1;
            state_nx_s = ST_IDLE;
          end else begin
            done_nx_s = 1'b0;
          end
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, pointer, counter and done-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      sp_r    <= SP_TOP;
      cnt_r   <= {WIDTH{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      sp_r    <= sp_nx_s;
      cnt_r   <= cnt_nx_s;
      done_r  <= done_nx_s;
    end
  end

  // Sticky error bits; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf_r <= 1'b0;
      err_unf_r <= 1'b0;
    end else begin
      err_ovf_r <= set_ovf_s | (err_ovf_r & ~bus.err_clr);
      err_unf_r <= set_unf_s | (err_unf_r & ~bus.err_clr);
    end
  end

  assign bus.op_ready = (state_r == ST_IDLE);
  assign bus.sp       = sp_r;
  assign bus.empty    = empty_s;
  assign bus.full     = full_s;
  assign bus.done     = done_r;
  assign bus.err_ovf  = err_ovf_r;
  assign bus.err_unf  = err_unf_r;

endmodule

// File: tb/tb_stack_ptr_ctrl.sv
// Self-checking bench for stack_ptr_ctrl: directed scenarios plus random
// operations scored against an arithmetic model of the stack pointer.
module tb_stack_ptr_ctrl;
  localparam int SP_TOP   = 'h3FFF;
  localparam int SP_LIMIT = 'h3C00;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   m_sp;
  logic m_ovf;
  logic m_unf;

  stack_ptr_ctrl_if #(.WIDTH(14)) bus ();

  stack_ptr_ctrl #(.WIDTH(14), .SP_TOP(14'h3FFF), .SP_LIMIT(14'h3C00)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_status(input string name);
    n_cmp++;
    if (bus.sp !== m_sp[13:0] || bus.err_ovf !== m_ovf || bus.err_unf !== m_unf ||
        bus.empty !== (m_sp == SP_TOP) || bus.full !== (m_sp == SP_LIMIT)) begin
      n_bad++;
      $display("FAIL %s: sp=%h ovf=%b unf=%b empty=%b full=%b, required sp=%h ovf=%b unf=%b",
               name, bus.sp, bus.err_ovf, bus.err_unf, bus.empty, bus.full,
               m_sp[13:0], m_ovf, m_unf);
    end
  endtask

  // Issue one operation and score every cycle until it completes.
  task automatic apply_op(input logic [1:0] code, input int n, input logic clr);
    int   start;
    int   d;
    int   cycles;
    int   room;
    logic abort;
    start = m_sp;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.op_count = n[13:0];
    bus.err_clr  = clr;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.err_clr  = 1'b0;
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (code == 2'b10 && n != 0) begin
      room   = start - SP_LIMIT;
      abort  = (n > room);
      d      = abort ? room : n;
      cycles = abort ? d + 1 : n;
      n_cmp++;
      if (bus.op_ready !== 1'b0 || bus.done !== 1'b0) begin
        n_bad++;
        $display("FAIL alloc_accept: op_ready=%b done=%b, required 0 0", bus.op_ready, bus.done);
      end
      for (int j = 1; j <= cycles; j++) begin
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.sp !== 14'(start - ((j < d) ? j : d))) begin
          n_bad++;
          $display("FAIL alloc_step%0d: sp=%h, required %h", j, bus.sp, 14'(start - ((j < d) ? j : d)));
        end
        n_cmp++;
        if (j == cycles && (bus.done !== 1'b1 || bus.op_ready !== 1'b1)) begin
          n_bad++;
          $display("FAIL alloc_done: done=%b op_ready=%b, required 1 1", bus.done, bus.op_ready);
        end else if (j != cycles && (bus.done !== 1'b0 || bus.op_ready !== 1'b0)) begin
          n_bad++;
          $display("FAIL alloc_busy%0d: done=%b op_ready=%b, required 0 0", j, bus.done, bus.op_ready);
        end
      end
      m_sp = start - d;
      if (abort) m_ovf = 1'b1;
      check_status("alloc_end");
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.done !== 1'b0) begin
        n_bad++;
        $display("FAIL alloc_done_pulse: done=%b, required 0", bus.done);
      end
    end else begin
      case (code)
        2'b00: if (m_sp == SP_LIMIT) m_ovf = 1'b1; else m_sp = m_sp - 1;
        2'b01: if (m_sp == SP_TOP) m_unf = 1'b1; else m_sp = m_sp + 1;
        2'b11: if (n > SP_TOP - m_sp) m_unf = 1'b1; else m_sp = m_sp + n;
        default: m_sp = m_sp;
      endcase
      n_cmp++;
      if (bus.done !== 1'b1 || bus.op_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL op%0d_done: done=%b op_ready=%b, required 1 1", code, bus.done, bus.op_ready);
      end
      check_status("single_op");
    end
  endtask

  task automatic clear_err();
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_status("err_clr");
  endtask

  task automatic test_reset();
    bus.op_valid = 1'b0;
    bus.op_code  = 2'b00;
    bus.op_count = 14'd0;
    bus.err_clr  = 1'b0;
    rst_n = 1'b0;
    m_sp  = SP_TOP;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #100;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_status("reset");
    n_cmp++;
    if (bus.op_ready !== 1'b1 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hs: op_ready=%b done=%b, required 1 0", bus.op_ready, bus.done);
    end
  endtask

  task automatic test_push_pop();
    apply_op(2'b00, 0, 1'b0);
    apply_op(2'b00, 0, 1'b0);
    apply_op(2'b00, 0, 1'b0);
    n_cmp++;
    if (bus.sp !== 14'h3FFC) begin
      n_bad++;
      $display("FAIL push3: sp=%h, required 3ffc", bus.sp);
    end
    apply_op(2'b01, 0, 1'b0);
    n_cmp++;
    if (bus.sp !== 14'h3FFD) begin
      n_bad++;
      $display("FAIL pop1: sp=%h, required 3ffd", bus.sp);
    end
    apply_op(2'b11, 2, 1'b0);
  endtask

  task automatic test_underflow();
    apply_op(2'b01, 0, 1'b0);
    n_cmp++;
    if (bus.err_unf !== 1'b1 || bus.sp !== 14'h3FFF) begin
      n_bad++;
      $display("FAIL pop_empty: unf=%b sp=%h, required 1 3fff", bus.err_unf, bus.sp);
    end
    clear_err();
    apply_op(2'b00, 0, 1'b0);
    apply_op(2'b11, 2, 1'b0);
    n_cmp++;
    if (bus.err_unf !== 1'b1 || bus.sp !== 14'h3FFE) begin
      n_bad++;
      $display("FAIL free_past_top: unf=%b sp=%h, required 1 3ffe", bus.err_unf, bus.sp);
    end
    apply_op(2'b11, 1, 1'b1);
    apply_op(2'b10, 0, 1'b0);
  endtask

  task automatic test_alloc();
    apply_op(2'b10, 5, 1'b0);
    apply_op(2'b11, 5, 1'b0);
    n_cmp++;
    if (bus.sp !== 14'h3FFF || bus.empty !== 1'b1) begin
      n_bad++;
      $display("FAIL alloc_free5: sp=%h empty=%b, required 3fff 1", bus.sp, bus.empty);
    end
  endtask

  task automatic test_alloc_abort();
    apply_op(2'b10, 'h3FD, 1'b0);
    apply_op(2'b10, 4, 1'b0);
    n_cmp++;
    if (bus.sp !== 14'h3C00 || bus.full !== 1'b1 || bus.err_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL alloc_abort: sp=%h full=%b ovf=%b, required 3c00 1 1", bus.sp, bus.full, bus.err_ovf);
    end
    apply_op(2'b00, 0, 1'b1);
    n_cmp++;
    if (bus.err_ovf !== 1'b1 || bus.sp !== 14'h3C00) begin
      n_bad++;
      $display("FAIL push_full_clr: ovf=%b sp=%h, required 1 3c00", bus.err_ovf, bus.sp);
    end
    apply_op(2'b11, 'h3FF, 1'b1);
  endtask

  task automatic test_reset_mid_alloc();
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = 2'b10;
    bus.op_count = 14'd100;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.sp !== 14'h3FF5) begin
      n_bad++;
      $display("FAIL mid_alloc: sp=%h, required 3ff5", bus.sp);
    end
    #2;
    rst_n = 1'b0;
    #1;
    m_sp  = SP_TOP;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_status("async_reset");
    n_cmp++;
    if (bus.op_ready !== 1'b1 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset_hs: op_ready=%b done=%b, required 1 0", bus.op_ready, bus.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0) done_seen++;
    end
    n_cmp++;
    if (done_seen != 0 || bus.sp !== 14'h3FFF) begin
      n_bad++;
      $display("FAIL reset_no_done: done_cycles=%0d sp=%h, required 0 3fff", done_seen, bus.sp);
    end
  endtask

  task automatic test_random();
    logic [1:0] code;
    int         n;
    apply_op(2'b10, 'h3F8, 1'b0);
    for (int i = 0; i < 80; i++) begin
      code = 2'($urandom_range(0, 3));
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 'h3FF)) : int'($urandom_range(0, 6));
      apply_op(code, n, ($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    test_reset();
    test_push_pop();
    test_underflow();
    test_alloc();
    test_alloc_abort();
    test_reset_mid_alloc();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stack_ptr_ctrl.md
# stack_ptr_ctrl

Stack-pointer controller for the cookie stack machine. It owns the 14-bit stack pointer register and sequences the 14-bit decrement unit (subone14b) for pushes and multi-word frame allocation. It also performs pop/free increments, bounds checks, and sticky error reporting. It sits between the control unit, which issues stack operations over a valid/ready handshake, and the data-memory address mux, which consumes `sp`.

## Interface
- `WIDTH`, 14, stack pointer and count width
- `SP_TOP`, 14'h3FFF, reset/empty value of `sp` (stack grows downward)
- `SP_LIMIT`, 14'h3C00, lowest legal `sp`; full when `sp == SP_LIMIT`; must satisfy `SP_LIMIT < SP_TOP`
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `op_valid`  in  1  control unit presents an operation
- `op_ready`  out  1  controller can accept an operation (high only in IDLE)
- `op_code`  in  2  00 push, 01 pop, 10 alloc, 11 free
- `op_count`  in  WIDTH  word count for alloc/free; ignored for push/pop
- `err_clr`  in  1  clears both sticky error bits
- `sp`  out  WIDTH  current stack pointer (registered)
- `empty`  out  1  `sp == SP_TOP`
- `full`  out  1  `sp == SP_LIMIT`
- `done`  out  1  one-cycle pulse when an accepted operation completes or aborts
- `err_ovf`  out  1  sticky: push or alloc attempted past `SP_LIMIT`
- `err_unf`  out  1  sticky: pop or free attempted past `SP_TOP`

## Operation
- Reset values: `sp = SP_TOP`, state IDLE, internal `cnt = 0`, `op_ready = 1`, `done = 0`, `err_ovf = err_unf = 0`; `empty = 1`, `full = 0`.
- Accept: `op_valid && op_ready` at a rising edge. Inputs are not sampled when `op_ready` is low.
- States: IDLE, ALLOC.
- push, from IDLE, one cycle:
  - `full`: set `err_ovf`, `sp` unchanged.
  - otherwise: `sp <= subone(sp)`.
- pop, from IDLE, one cycle:
  - `empty`: set `err_unf`, `sp` unchanged.
  - otherwise: `sp <= sp + 1`.
- free N, from IDLE, one cycle. Compare in WIDTH+1 bits, with no wrap:
  - `N > SP_TOP - sp`: set `err_unf`, `sp` unchanged.
  - otherwise: `sp <= sp + N`.
  - N = 0 is a no-op.
- alloc N:
  - N = 0 completes in one cycle with no change.
  - Otherwise load `cnt <= N` and go to ALLOC.
  - Each ALLOC cycle, if `full`: set `err_ovf`, go to IDLE (abort); decrements already made stand.
  - Otherwise `sp <= subone(sp)`, `cnt <= cnt - 1`; when `cnt == 1`, go to IDLE.
- One decrementer instance feeds `sp`. The `cnt` decrement uses a second subone14b instance.
- The decrementer is never presented with `sp = 0`, because the full check precedes every decrement.
- `err_*` set has priority over `err_clr` in the same cycle.
- `done`: registered, high for exactly one cycle after each completing or aborting edge. It is never asserted for an unaccepted `op_valid`.

## Timing
- Accept at edge k (push/pop/free/alloc 0): `sp` and error bits valid after edge k, `done` high in cycle k+1, `op_ready` stays high.
  - Back-to-back single-cycle ops may issue every cycle.
- Alloc N ≥ 1 accepted at edge k:
  - `op_ready` low from after edge k until edge k+N.
  - Decrements at edges k+1 … k+N, returning to IDLE at edge k+N.
  - `done` high in cycle k+N+1.
- Abort at edge k+j (`full` seen): IDLE after edge k+j, `done` in cycle k+j+1.
- `empty` and `full` are decoded from the `sp` register and change with `sp`.
- `rst_n` low at any time, including mid-ALLOC, immediately forces all reset values without waiting for a clock edge. The first accept is possible at the first rising edge after `rst_n` rises.

## Test plan
- Reset: hold `rst_n` = 0 for 100 ns, then release → `sp` = 0x3FFF, `empty` = 1, `full` = 0, `op_ready` = 1, `done` = 0, errors 0.
- push ×3 back-to-back, then pop ×1 → `sp` 0x3FFE, 0x3FFD, 0x3FFC, 0x3FFD; `done` high each following cycle.
- pop at `sp` = 0x3FFF → `err_unf` = 1, `sp` stays 0x3FFF; pulse `err_clr` → `err_unf` = 0; free 2 at `sp` = 0x3FFE → `err_unf` = 1, `sp` stays 0x3FFE.
- alloc 5 at `sp` = 0x3FFF → `op_ready` low 5 cycles, `sp` steps down to 0x3FFA, single `done` pulse; then free 5 → `sp` = 0x3FFF, `empty` = 1.
- alloc 4 at `sp` = 0x3C02 → two decrements to 0x3C00, `full` = 1, `err_ovf` = 1, abort with `done` after the 3rd ALLOC cycle; push → `err_ovf` stays 1, `sp` stays 0x3C00.
- alloc 100 at `sp` = 0x3FFF, assert `rst_n` low after 10 decrements (`sp` = 0x3FF5) → immediately `sp` = 0x3FFF, `op_ready` = 1, no `done` pulse.
